// File: rtl/mfhwt_pkg.sv
// Shared defaults and width helpers for the MFHWT lane FIFO bank.
package mfhwt_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 4;
    localparam int DEPTH_DEF  = 160;

    // Level counters must be able to hold the value DEPTH itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mfhwt_lane_fifo_bank_if.sv
// Producer/consumer bus of the lane FIFO bank; master drives requests, slave is the bank.
interface mfhwt_lane_fifo_bank_if
    import mfhwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int LVL_W  = lvl_w(DEPTH_DEF)
);
    logic [LANES-1:0]        iWrreq;
    logic [DATA_W-1:0]       iData;
    logic                    iRdreq;
    logic [LANES-1:0]        oFull;
    logic                    oEmpty;
    logic                    oValid;
    logic                    oDvalid;
    logic [LANES*DATA_W-1:0] oData;
    logic [LANES*LVL_W-1:0]  oLevel;
    logic                    oOvf;
    logic                    oUdf;
    logic                    oMulti;

    modport master (
        output iWrreq, iData, iRdreq,
        input  oFull, oEmpty, oValid, oDvalid, oData, oLevel, oOvf, oUdf, oMulti
    );

    modport slave (
        input  iWrreq, iData, iRdreq,
        output oFull, oEmpty, oValid, oDvalid, oData, oLevel, oOvf, oUdf, oMulti
    );
endinterface

// File: rtl/mfhwt_lane_fifo.sv
// One FIFO lane: inferred RAM, wrapping pointers and a level counter.
// Write/read enables arrive already qualified by the bank.
module mfhwt_lane_fifo
    import mfhwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LVL_W  = lvl_w(DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Storage array, deliberately without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Next-state for pointers and level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (re) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({we, re})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/mfhwt_lane_fifo_bank.sv
// Multi-lane coefficient FIFO bank: one-hot lane writes, aligned column reads.
// Define MFHWT_FIFO_BANK_FWFT_EN for show-ahead output; default is 1-cycle registered read.
module mfhwt_lane_fifo_bank
    import mfhwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                  iClk,
    input  logic                  iRstn,
    input  logic                  iClear,
    mfhwt_lane_fifo_bank_if.slave bus
);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [LVL_W-1:0]        level_s [LANES];
    logic [DATA_W-1:0]       head_s  [LANES];
    logic [LANES-1:0]        full_s;
    logic [LANES-1:0]        nonempty_s;
    logic [LANES-1:0]        sel_s;
    logic [LANES-1:0]        we_s;
    logic                    valid_s;
    logic                    rd_acc_s;
    logic                    drop_s;
    logic                    udf_s;
    logic                    multi_s;
    logic [LANES*DATA_W-1:0] col_s;
    logic [LANES*LVL_W-1:0]  lvl_pack_s;
    logic                    ovf_q, udf_q, multi_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mfhwt_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .LVL_W  (LVL_W)
        ) u_lane (
            .clk   (iClk),
            .rst_n (iRstn),
            .clr   (iClear),
            .we    (we_s[k]),
            .re    (rd_acc_s),
            .wdata (bus.iData),
            .head  (head_s[k]),
            .level (level_s[k])
        );
        assign full_s[k]     = (level_s[k] == LVL_W'(DEPTH));
        assign nonempty_s[k] = (level_s[k] != '0);
    end

    assign valid_s = &nonempty_s;

    // Lowest set request bit wins; a full lane still accepts when the column pops.
    always_comb begin
        sel_s    = bus.iWrreq & (~bus.iWrreq + LANES'(1));
        rd_acc_s = 1'b0;
        we_s     = '0;
        drop_s   = 1'b0;
        udf_s    = 1'b0;
        multi_s  = 1'b0;
        if (iClear) begin
            rd_acc_s = 1'b0;
            we_s     = '0;
        end else begin
            rd_acc_s = bus.iRdreq & valid_s;
            we_s     = sel_s & (~full_s | {LANES{rd_acc_s}});
            drop_s   = |(sel_s & ~we_s);
            udf_s    = bus.iRdreq & ~valid_s;
            multi_s  = |(bus.iWrreq & (bus.iWrreq - LANES'(1)));
        end
    end

    // Column and level packing, lane k in slice k.
    always_comb begin
        col_s      = '0;
        lvl_pack_s = '0;
        for (int k = 0; k < LANES; k++) begin
            col_s[k*DATA_W +: DATA_W]  = head_s[k];
            lvl_pack_s[k*LVL_W +: LVL_W] = level_s[k];
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            multi_q <= 1'b0;
        end else if (iClear) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_q | drop_s;
            udf_q   <= udf_q | udf_s;
            multi_q <= multi_q | multi_s;
        end
    end

`ifdef MFHWT_FIFO_BANK_FWFT_EN
    // Stale RAM behind an empty lane is masked so the column reads zero until valid.
    assign bus.oData   = valid_s ? col_s : '0;
    assign bus.oDvalid = valid_s;
`else
    logic [LANES*DATA_W-1:0] data_q;
    logic                    dvalid_q;

    // Registered read port: column captured on the accepting edge.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            data_q   <= '0;
            dvalid_q <= 1'b0;
        end else if (iClear) begin
            data_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_acc_s;
            if (rd_acc_s) begin
                data_q <= col_s;
            end
        end
    end

    assign bus.oData   = data_q;
    assign bus.oDvalid = dvalid_q;
`endif

    assign bus.oFull  = full_s;
    assign bus.oEmpty = ~|nonempty_s;
    assign bus.oValid = valid_s;
    assign bus.oLevel = lvl_pack_s;
    assign bus.oOvf   = ovf_q;
    assign bus.oUdf   = udf_q;
    assign bus.oMulti = multi_q;

endmodule

// File: tb/tb_mfhwt_lane_fifo_bank.sv
// Directed self-checking bench for mfhwt_lane_fifo_bank (LANES=4, DEPTH=160).
module tb_mfhwt_lane_fifo_bank;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int DP = 160;
    localparam int LW = 8;

`ifdef MFHWT_FIFO_BANK_FWFT_EN
    localparam logic FWFT = 1'b1;
`else
    localparam logic FWFT = 1'b0;
`endif

    logic iClk = 1'b0;
    logic iRstn;
    logic iClear;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 iClk = ~iClk;

    mfhwt_lane_fifo_bank_if #(.DATA_W(DW), .LANES(LN), .LVL_W(LW)) bus ();

    mfhwt_lane_fifo_bank #(.DATA_W(DW), .LANES(LN), .DEPTH(DP)) dut (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .iClear (iClear),
        .bus    (bus)
    );

    // {oFull[3:0], oEmpty, oValid, oDvalid, oOvf, oUdf, oMulti}
    function automatic logic [9:0] st();
        return {bus.oFull, bus.oEmpty, bus.oValid, bus.oDvalid, bus.oOvf, bus.oUdf, bus.oMulti};
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [3:0] wr, input logic [15:0] d, input logic rd, input logic clr);
        bus.iWrreq = wr;
        bus.iData  = d;
        bus.iRdreq = rd;
        iClear     = clr;
        tick();
        bus.iWrreq = 4'b0000;
        bus.iRdreq = 1'b0;
        iClear     = 1'b0;
    endtask

    task automatic test_reset();
        iRstn = 1'b0; iClear = 1'b0;
        bus.iWrreq = 4'b0000; bus.iData = 16'h0000; bus.iRdreq = 1'b0;
        #12 iRstn = 1'b1;
        tick();
        total_cnt++;
        if (bus.oLevel !== 32'h0) $display("FAIL reset_level: got %h want %h", bus.oLevel, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (st() !== 10'b0000_1_0_0_000) $display("FAIL reset_status: got %b want %b", st(), 10'b0000_1_0_0_000);
        else pass_cnt++;
        total_cnt++;
        if (bus.oData !== 64'h0) $display("FAIL reset_data: got %h want %h", bus.oData, 64'h0);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp_col = 64'h0013_0012_0011_0010;
        drive(4'b0001, 16'h0010, 1'b0, 1'b0);
        drive(4'b0010, 16'h0011, 1'b0, 1'b0);
        drive(4'b0100, 16'h0012, 1'b0, 1'b0);
        total_cnt++;
        if (st() !== 10'b0000_0_0_0_000) $display("FAIL fill_not_valid: got %b want %b", st(), 10'b0000_0_0_0_000);
        else pass_cnt++;
        drive(4'b1000, 16'h0013, 1'b0, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h01010101) $display("FAIL fill_level: got %h want %h", bus.oLevel, 32'h01010101);
        else pass_cnt++;
        total_cnt++;
        if (st() !== {4'b0000, 1'b0, 1'b1, FWFT, 3'b000}) $display("FAIL fill_valid: got %b want %b", st(), {4'b0000, 1'b0, 1'b1, FWFT, 3'b000});
        else pass_cnt++;
`ifdef MFHWT_FIFO_BANK_FWFT_EN
        total_cnt++;
        if (bus.oData !== exp_col) $display("FAIL fill_showahead: got %h want %h", bus.oData, exp_col);
        else pass_cnt++;
`endif
        drive(4'b0000, 16'h0000, 1'b1, 1'b0);
        total_cnt++;
        if (st() !== {4'b0000, 1'b1, 1'b0, ~FWFT, 3'b000}) $display("FAIL drain_status: got %b want %b", st(), {4'b0000, 1'b1, 1'b0, ~FWFT, 3'b000});
        else pass_cnt++;
`ifndef MFHWT_FIFO_BANK_FWFT_EN
        total_cnt++;
        if (bus.oData !== exp_col) $display("FAIL drain_data: got %h want %h", bus.oData, exp_col);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.oDvalid !== 1'b0 || bus.oData !== exp_col)
            $display("FAIL drain_hold: got dv=%b %h want dv=0 %h", bus.oDvalid, bus.oData, exp_col);
        else pass_cnt++;
`endif
    endtask

    task automatic test_full();
        logic [63:0] exp_col = 64'hA003_A002_A001_0000;
        for (int i = 0; i < DP; i++) drive(4'b0001, 16'(i), 1'b0, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h000000A0 || st() !== 10'b0001_0_0_0_000)
            $display("FAIL full_set: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h000000A0, 10'b0001_0_0_0_000);
        else pass_cnt++;
        drive(4'b0001, 16'hDEAD, 1'b0, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h000000A0 || st() !== 10'b0001_0_0_0_100)
            $display("FAIL full_drop: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h000000A0, 10'b0001_0_0_0_100);
        else pass_cnt++;
        drive(4'b0010, 16'hA001, 1'b0, 1'b0);
        drive(4'b0100, 16'hA002, 1'b0, 1'b0);
        drive(4'b1000, 16'hA003, 1'b0, 1'b0);
`ifdef MFHWT_FIFO_BANK_FWFT_EN
        total_cnt++;
        if (bus.oData !== exp_col) $display("FAIL full_showahead: got %h want %h", bus.oData, exp_col);
        else pass_cnt++;
`endif
        drive(4'b0001, 16'hD000, 1'b1, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h000000A0 || st() !== {4'b0001, 1'b0, 1'b0, ~FWFT, 3'b100})
            $display("FAIL full_wr_rd: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h000000A0, {4'b0001, 1'b0, 1'b0, ~FWFT, 3'b100});
        else pass_cnt++;
`ifndef MFHWT_FIFO_BANK_FWFT_EN
        total_cnt++;
        if (bus.oData !== exp_col) $display("FAIL full_wr_rd_data: got %h want %h", bus.oData, exp_col);
        else pass_cnt++;
`endif
        drive(4'b0000, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [15:0] lq [LN][$];
        logic [63:0] exp_col;
        logic [31:0] exp_lvl;
        logic [1:0]  ln;
        logic        rd;
        int          bad = 0;
        for (int c = 0; c < 800; c++) begin
            ln = c[1:0];
            rd = (ln == 2'd3) && bus.oValid;
            exp_col = 64'h0;
            if (rd) begin
                for (int k = 0; k < LN; k++) exp_col[k*16 +: 16] = lq[k].pop_front();
`ifdef MFHWT_FIFO_BANK_FWFT_EN
                total_cnt++;
                if (bus.oData !== exp_col) begin
                    $display("FAIL wrap_col: cycle %0d got %h want %h", c, bus.oData, exp_col);
                    bad++;
                end else pass_cnt++;
`endif
            end
            lq[ln].push_back(16'(c + 256));
            drive(4'b0001 << ln, 16'(c + 256), rd, 1'b0);
`ifndef MFHWT_FIFO_BANK_FWFT_EN
            if (rd) begin
                total_cnt++;
                if (bus.oData !== exp_col || bus.oDvalid !== 1'b1) begin
                    $display("FAIL wrap_col: cycle %0d got dv=%b %h want dv=1 %h", c, bus.oDvalid, bus.oData, exp_col);
                    bad++;
                end else pass_cnt++;
            end
`endif
            if (bad > 5) break;
        end
        for (int k = 0; k < LN; k++) exp_lvl[k*8 +: 8] = 8'(lq[k].size());
        total_cnt++;
        if (bus.oLevel !== exp_lvl || bus.oOvf !== 1'b0 || bus.oUdf !== 1'b0)
            $display("FAIL wrap_end: got lvl=%h ovf=%b udf=%b want lvl=%h ovf=0 udf=0", bus.oLevel, bus.oOvf, bus.oUdf, exp_lvl);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        drive(4'b0000, 16'h0000, 1'b0, 1'b1);
        drive(4'b0110, 16'hBEEF, 1'b0, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h00000100 || st() !== 10'b0000_0_0_0_001)
            $display("FAIL multi: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h00000100, 10'b0000_0_0_0_001);
        else pass_cnt++;
        drive(4'b0000, 16'h0000, 1'b1, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h00000100 || st() !== 10'b0000_0_0_0_011)
            $display("FAIL underflow: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h00000100, 10'b0000_0_0_0_011);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        drive(4'b0001, 16'h1111, 1'b0, 1'b0);
        drive(4'b0100, 16'h2222, 1'b0, 1'b0);
        drive(4'b1000, 16'h3333, 1'b0, 1'b0);
        drive(4'b0001, 16'h1234, 1'b1, 1'b1);
        total_cnt++;
        if (bus.oLevel !== 32'h0 || st() !== 10'b0000_1_0_0_000)
            $display("FAIL flush: got lvl=%h st=%b want lvl=%h st=%b", bus.oLevel, st(), 32'h0, 10'b0000_1_0_0_000);
        else pass_cnt++;
    endtask

    task automatic fill3();
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < LN; k++)
                drive(4'b0001 << k, 16'((k << 8) | j), 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_col;
        fill3();
        total_cnt++;
        if (bus.oLevel !== 32'h03030303) $display("FAIL b2b_level: got %h want %h", bus.oLevel, 32'h03030303);
        else pass_cnt++;
        bus.iRdreq = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_col = {16'h0300 | 16'(j), 16'h0200 | 16'(j), 16'h0100 | 16'(j), 16'(j)};
`ifdef MFHWT_FIFO_BANK_FWFT_EN
            total_cnt++;
            if (bus.oData !== exp_col) $display("FAIL b2b_col%0d: got %h want %h", j, bus.oData, exp_col);
            else pass_cnt++;
            tick();
`else
            tick();
            total_cnt++;
            if (bus.oData !== exp_col || bus.oDvalid !== 1'b1)
                $display("FAIL b2b_col%0d: got dv=%b %h want dv=1 %h", j, bus.oDvalid, bus.oData, exp_col);
            else pass_cnt++;
`endif
        end
        bus.iRdreq = 1'b0;
        total_cnt++;
        if (bus.oLevel !== 32'h0 || bus.oEmpty !== 1'b1 || bus.oUdf !== 1'b0)
            $display("FAIL b2b_end: got lvl=%h empty=%b udf=%b want lvl=0 empty=1 udf=0", bus.oLevel, bus.oEmpty, bus.oUdf);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        fill3();
        drive(4'b0011, 16'h5555, 1'b0, 1'b0);
        total_cnt++;
        if (bus.oLevel !== 32'h03030304 || bus.oMulti !== 1'b1)
            $display("FAIL pre_reset: got lvl=%h multi=%b want lvl=%h multi=1", bus.oLevel, bus.oMulti, 32'h03030304);
        else pass_cnt++;
        #2 iRstn = 1'b0;
        #1;
        total_cnt++;
        if (bus.oLevel !== 32'h0 || st() !== 10'b0000_1_0_0_000 || bus.oData !== 64'h0)
            $display("FAIL async_reset: got lvl=%h st=%b data=%h want lvl=0 st=%b data=0", bus.oLevel, st(), bus.oData, 10'b0000_1_0_0_000);
        else pass_cnt++;
        #2 iRstn = 1'b1;
        tick();
        total_cnt++;
        if (bus.oLevel !== 32'h0 || bus.oEmpty !== 1'b1)
            $display("FAIL post_reset: got lvl=%h empty=%b want lvl=0 empty=1", bus.oLevel, bus.oEmpty);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full();
        test_wrap();
        test_errors();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
